// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit: branch_control
// encodings, BTB entry kinds and the 2-bit saturating counter update.
package bpu_pkg;

  localparam logic [2:0] BcBeq  = 3'b000;
  localparam logic [2:0] BcBne  = 3'b001;
  localparam logic [2:0] BcBgt  = 3'b010;
  localparam logic [2:0] BcBgte = 3'b011;
  localparam logic [2:0] BcBle  = 3'b100;
  localparam logic [2:0] BcBleq = 3'b101;
  localparam logic [2:0] BcBleu = 3'b110;
  localparam logic [2:0] BcBgtu = 3'b111;

  typedef enum logic [1:0] {
    KindBr  = 2'd0,
    KindJmp = 2'd1,
    KindRet = 2'd2
  } bpu_kind_e;

  // Tag and target live in separate arrays so their widths can follow XLEN.
  typedef struct packed {
    logic      valid;
    logic [1:0] ctr;
    bpu_kind_e kind;
  } btb_entry_t;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty leaves it empty.
module bpu_ras #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] top_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  ptr_q, ptr_d, top_ptr;  // ptr_q is the next free slot
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign top_ptr = (ptr_q == '0) ? PtrW'(Depth - 1) : ptr_q - 1'b1;
  assign top_o   = mem_q[top_ptr];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[ptr_q] = data_i;
      ptr_d = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + 1'b1;
      if (cnt_q != CntW'(Depth)) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = top_ptr;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolver with a direct-mapped BTB for fetch-stage prediction.
// Optional return-address stack enabled by defining BRANCH_PREDICT_RAS_EN.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs_val,
  input  logic [XLEN-1:0] ex_rt_val,
  input  logic [15:0]     ex_immediate,
  input  logic [25:0]     ex_jump_address,
  input  logic [2:0]      ex_branch_control,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_is_jal,
  input  logic            ex_is_jr,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            resolved_taken
);
  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TW  = XLEN - IDX - 2;

  btb_entry_t      meta_q [ENTRIES];
  btb_entry_t      meta_d [ENTRIES];
  logic [TW-1:0]   tag_q  [ENTRIES];
  logic [TW-1:0]   tag_d  [ENTRIES];
  logic [XLEN-1:0] tgt_q  [ENTRIES];
  logic [XLEN-1:0] tgt_d  [ENTRIES];

  logic            mis_q, mis_d, rt_q, rt_d;
  logic [XLEN-1:0] redir_q, redir_d;

  logic [IDX-1:0]  f_idx, ex_idx;
  logic            f_hit, ex_hit;
  logic            ras_valid;
  logic [XLEN-1:0] ras_top;
  logic            br_taken, act_taken;
  logic [XLEN-1:0] ex_pc4, br_target, jmp_target, act_target;

  assign f_idx  = f_pc[IDX+1:2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign f_hit  = f_valid && meta_q[f_idx].valid && (tag_q[f_idx] == f_pc[XLEN-1:IDX+2]);
  assign ex_hit = meta_q[ex_idx].valid && (tag_q[ex_idx] == ex_pc[XLEN-1:IDX+2]);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = f_pc + XLEN'(4);
    if (f_hit && !rst) begin
      case (meta_q[f_idx].kind)
        KindBr:  pred_taken = meta_q[f_idx].ctr[1];
        KindJmp: pred_taken = 1'b1;
        KindRet: pred_taken = ras_valid;
        default: pred_taken = 1'b0;
      endcase
    end
    if (pred_taken) begin
      pred_target = (meta_q[f_idx].kind == KindRet) ? ras_top : tgt_q[f_idx];
    end
  end

  assign ex_pc4     = ex_pc + XLEN'(4);
  assign br_target  = ex_pc4 + {{(XLEN-18){ex_immediate[15]}}, ex_immediate, 2'b00};
  assign jmp_target = {ex_pc[XLEN-1:28], ex_jump_address, 2'b00};

  always_comb begin
    br_taken = 1'b0;
    unique case (ex_branch_control)
      BcBeq:  br_taken = (ex_rs_val == ex_rt_val);
      BcBne:  br_taken = (ex_rs_val != ex_rt_val);
      BcBgt:  br_taken = ($signed(ex_rs_val) >  $signed(ex_rt_val));
      BcBgte: br_taken = ($signed(ex_rs_val) >= $signed(ex_rt_val));
      BcBle:  br_taken = ($signed(ex_rs_val) <  $signed(ex_rt_val));
      BcBleq: br_taken = ($signed(ex_rs_val) <= $signed(ex_rt_val));
      BcBleu: br_taken = (ex_rs_val < ex_rt_val);
      BcBgtu: br_taken = (ex_rs_val > ex_rt_val);
    endcase
  end

  assign act_taken  = ex_is_branch ? br_taken : (ex_is_jump | ex_is_jr);
  assign act_target = ex_is_jr ? ex_rs_val : (ex_is_jump ? jmp_target : br_target);

  always_comb begin
    mis_d   = ex_valid && ((act_taken != ex_pred_taken) ||
                           (act_taken && (act_target != ex_pred_target)));
    redir_d = ex_valid ? (act_taken ? act_target : ex_pc4) : redir_q;
    rt_d    = ex_valid ? act_taken : rt_q;
  end

  always_comb begin
    meta_d = meta_q;
    tag_d  = tag_q;
    tgt_d  = tgt_q;
    if (ex_valid) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          meta_d[ex_idx].ctr = ctr_update(meta_q[ex_idx].ctr, br_taken);
          if (br_taken) tgt_d[ex_idx] = act_target;
        end else if (br_taken) begin
          meta_d[ex_idx] = '{valid: 1'b1, ctr: ctr_update(CTR_INIT, 1'b1), kind: KindBr};
          tag_d[ex_idx]  = ex_pc[XLEN-1:IDX+2];
          tgt_d[ex_idx]  = act_target;
        end
      end else if (ex_is_jump) begin
        meta_d[ex_idx] = '{valid: 1'b1, ctr: 2'b11, kind: KindJmp};
        tag_d[ex_idx]  = ex_pc[XLEN-1:IDX+2];
        tgt_d[ex_idx]  = act_target;
      end
`ifdef BRANCH_PREDICT_RAS_EN
      else if (ex_is_jr) begin
        meta_d[ex_idx] = '{valid: 1'b1, ctr: 2'b11, kind: KindRet};
        tag_d[ex_idx]  = ex_pc[XLEN-1:IDX+2];
        tgt_d[ex_idx]  = act_target;
      end
`endif
    end
  end

`ifdef BRANCH_PREDICT_RAS_EN
  logic ras_empty;

  bpu_ras #(
    .Depth(RAS_DEPTH),
    .Width(XLEN)
  ) u_ras (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (ex_valid & ex_is_jal),
    .pop_i  (ex_valid & ex_is_jr),
    .data_i (ex_pc4),
    .top_o  (ras_top),
    .empty_o(ras_empty)
  );
  assign ras_valid = !ras_empty;
`else
  logic        unused_jal;
  logic [31:0] unused_ras_depth;
  assign unused_jal       = ex_is_jal;
  assign unused_ras_depth = 32'(RAS_DEPTH);
  assign ras_top          = '0;
  assign ras_valid        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        meta_q[i] <= '{valid: 1'b0, ctr: CTR_INIT, kind: KindBr};
        tag_q[i]  <= '0;
        tgt_q[i]  <= '0;
      end
      mis_q   <= 1'b0;
      redir_q <= '0;
      rt_q    <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      mis_q   <= mis_d;
      redir_q <= redir_d;
      rt_q    <= rt_d;
    end
  end

  assign mispredict     = mis_q;
  assign redirect_pc    = redir_q;
  assign resolved_taken = rt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed cases plus randomized
// traffic against a table/queue model of the predictor.
module tb_branch_predict_unit;
  localparam int unsigned ENTRIES   = 16;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int          CTR_INIT  = 1;
`ifdef BRANCH_PREDICT_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, f_valid, pred_taken, ex_valid;
  logic [31:0] f_pc, pred_target, ex_pc, ex_rs_val, ex_rt_val, ex_pred_target, redirect_pc;
  logic [15:0] ex_immediate;
  logic [25:0] ex_jump_address;
  logic [2:0]  ex_branch_control;
  logic        ex_is_branch, ex_is_jump, ex_is_jal, ex_is_jr, ex_pred_taken;
  logic        mispredict, resolved_taken;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .XLEN(32), .ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_immediate(ex_immediate), .ex_jump_address(ex_jump_address),
    .ex_branch_control(ex_branch_control), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_is_jal(ex_is_jal), .ex_is_jr(ex_is_jr),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .resolved_taken(resolved_taken)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: each slot remembers the full word address of the owning instruction.
  bit          m_valid [ENTRIES];
  logic [29:0] m_word  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_kind  [ENTRIES];  // 0 branch, 1 jump, 2 return
  logic [31:0] m_ras[$];
  logic        e_mis = 1'b0;
  logic [31:0] e_redir = '0;
  logic        e_rt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_pred(output logic t, output logic [31:0] tgt);
    int i;
    i   = int'((f_pc >> 2) % ENTRIES);
    t   = 1'b0;
    tgt = f_pc + 4;
    if (!rst && f_valid && m_valid[i] && m_word[i] == f_pc[31:2]) begin
      if (m_kind[i] == 0) t = (m_ctr[i] >= 2);
      else if (m_kind[i] == 1) t = 1'b1;
      else t = RasEn && (m_ras.size() > 0);
      if (t) tgt = (m_kind[i] == 2) ? m_ras[$] : m_tgt[i];
    end
  endtask

  task automatic outcome(output logic t, output logic [31:0] tgt);
    t   = 1'b0;
    tgt = ex_pc + 4;
    if (ex_is_branch) begin
      case (ex_branch_control)
        3'd0: t = (ex_rs_val == ex_rt_val);
        3'd1: t = (ex_rs_val != ex_rt_val);
        3'd2: t = (int'(ex_rs_val) >  int'(ex_rt_val));
        3'd3: t = (int'(ex_rs_val) >= int'(ex_rt_val));
        3'd4: t = (int'(ex_rs_val) <  int'(ex_rt_val));
        3'd5: t = (int'(ex_rs_val) <= int'(ex_rt_val));
        3'd6: t = (ex_rs_val < ex_rt_val);
        default: t = (ex_rs_val > ex_rt_val);
      endcase
      tgt = ex_pc + 4 + 32'(int'($signed(ex_immediate)) * 4);
    end else if (ex_is_jump) begin
      t   = 1'b1;
      tgt = (ex_pc & 32'hF000_0000) | (32'(ex_jump_address) << 2);
    end else if (ex_is_jr) begin
      t   = 1'b1;
      tgt = ex_rs_val;
    end
  endtask

  task automatic alloc(input int i, input logic [31:0] tgt, input int kind, input int ctr);
    m_valid[i] = 1'b1;
    m_word[i]  = ex_pc[31:2];
    m_tgt[i]   = tgt;
    m_kind[i]  = kind;
    m_ctr[i]   = ctr;
  endtask

  task automatic model_edge();
    logic t;
    logic [31:0] tgt;
    int i;
    int c;
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = CTR_INIT;
      end
      m_ras.delete();
      e_mis = 1'b0; e_redir = '0; e_rt = 1'b0;
    end else if (!ex_valid) begin
      e_mis = 1'b0;
    end else begin
      i = int'((ex_pc >> 2) % ENTRIES);
      outcome(t, tgt);
      e_mis   = (t != ex_pred_taken) || (t && tgt != ex_pred_target);
      e_redir = t ? tgt : ex_pc + 4;
      e_rt    = t;
      if (ex_is_branch) begin
        if (m_valid[i] && m_word[i] == ex_pc[31:2]) begin
          if (t) m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
          else   m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
          if (t) m_tgt[i] = tgt;
        end else if (t) begin
          c = (CTR_INIT + 1 > 3) ? 3 : CTR_INIT + 1;
          alloc(i, tgt, 0, c);
        end
      end else if (ex_is_jump) begin
        alloc(i, tgt, 1, 3);
        if (ex_is_jal && RasEn) begin
          m_ras.push_back(ex_pc + 4);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
      end else if (ex_is_jr && RasEn) begin
        alloc(i, tgt, 2, 3);
        if (m_ras.size() > 0) void'(m_ras.pop_back());
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    logic        t;
    logic [31:0] tg;
    if (chk_en) begin
      model_pred(t, tg);
      check("pred_taken", {31'b0, pred_taken}, {31'b0, t});
      check("pred_target", pred_target, tg);
      check("mispredict", {31'b0, mispredict}, {31'b0, e_mis});
      check("redirect_pc", redirect_pc, e_redir);
      check("resolved_taken", {31'b0, resolved_taken}, {31'b0, e_rt});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_is_jal = 0; ex_is_jr = 0;
    ex_pc = '0; ex_rs_val = '0; ex_rt_val = '0; ex_immediate = '0; ex_jump_address = '0;
    ex_branch_control = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic br(input logic [31:0] pc, input logic [2:0] ctl, input logic [31:0] rs,
                    input logic [31:0] rt, input logic [15:0] imm, input logic pt,
                    input logic [31:0] ptg);
    clear_ex();
    ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_branch_control = ctl;
    ex_rs_val = rs; ex_rt_val = rt; ex_immediate = imm; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic jmp(input logic [31:0] pc, input logic [25:0] addr, input logic jal,
                     input logic pt, input logic [31:0] ptg);
    clear_ex();
    ex_valid = 1; ex_is_jump = 1; ex_is_jal = jal; ex_pc = pc; ex_jump_address = addr;
    ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic jr(input logic [31:0] pc, input logic [31:0] rs, input logic pt,
                    input logic [31:0] ptg);
    clear_ex();
    ex_valid = 1; ex_is_jr = 1; ex_pc = pc; ex_rs_val = rs; ex_pred_taken = pt;
    ex_pred_target = ptg;
  endtask

  function automatic logic [31:0] pc_of(input int s);
    return (s < 8) ? 32'h0040_0000 + 32'(4 * s) : 32'h0040_0040 + 32'(4 * (s - 8));
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 3));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        pt;
    logic [31:0] ptg;
    int          s;

    rst = 1; f_valid = 0; f_pc = '0; clear_ex();
    tick(); tick();
    rst = 0; chk_en = 1;

    // Cold lookup after reset
    f_valid = 1; f_pc = 32'h0040_0010;
    at_neg();
    check("reset_mispredict", {31'b0, mispredict}, 32'd0);
    check("reset_redirect", redirect_pc, 32'd0);
    check("reset_resolved", {31'b0, resolved_taken}, 32'd0);
    check("cold_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("cold_pred_target", pred_target, 32'h0040_0014);

    // beq taken, unpredicted: allocates with ctr=2
    br(32'h100, 3'd0, 32'd5, 32'd5, 16'd4, 1'b0, 32'd0);
    tick(); clear_ex(); f_pc = 32'h100;
    at_neg();
    check("beq_mispredict", {31'b0, mispredict}, 32'd1);
    check("beq_redirect", redirect_pc, 32'h114);
    check("beq_lookup_taken", {31'b0, pred_taken}, 32'd1);
    check("beq_lookup_target", pred_target, 32'h114);

    // Not-taken twice: 2 -> 1 -> 0, then saturates at 0
    br(32'h100, 3'd0, 32'd5, 32'd6, 16'd4, 1'b1, 32'h114);
    tick(); clear_ex(); at_neg();
    check("nt1_mispredict", {31'b0, mispredict}, 32'd1);
    check("nt1_redirect", redirect_pc, 32'h104);
    check("nt1_pred", {31'b0, pred_taken}, 32'd0);
    br(32'h100, 3'd0, 32'd5, 32'd6, 16'd4, 1'b0, 32'd0);
    tick(); clear_ex(); at_neg();
    check("nt2_mispredict", {31'b0, mispredict}, 32'd0);
    br(32'h100, 3'd0, 32'd5, 32'd6, 16'd4, 1'b0, 32'd0);
    tick(); clear_ex(); at_neg();
    check("nt3_pred", {31'b0, pred_taken}, 32'd0);
    br(32'h100, 3'd0, 32'd5, 32'd5, 16'd4, 1'b0, 32'd0);
    tick(); clear_ex(); at_neg();
    check("sat_low_pred", {31'b0, pred_taken}, 32'd0);
    br(32'h100, 3'd0, 32'd5, 32'd5, 16'd4, 1'b0, 32'd0);
    tick(); clear_ex(); at_neg();
    check("retrain_pred", {31'b0, pred_taken}, 32'd1);

    // Jump: redirect, then predicted and no mispredict
    jmp(32'h0040_0020, 26'h010_0040, 1'b0, 1'b0, 32'd0);
    tick(); clear_ex(); f_pc = 32'h0040_0020;
    at_neg();
    check("j_redirect", redirect_pc, 32'h0040_0100);
    check("j_lookup_taken", {31'b0, pred_taken}, 32'd1);
    check("j_lookup_target", pred_target, 32'h0040_0100);
    jmp(32'h0040_0020, 26'h010_0040, 1'b0, pred_taken, pred_target);
    tick(); clear_ex(); at_neg();
    check("j_no_mispredict", {31'b0, mispredict}, 32'd0);

    // Signed/unsigned split
    br(32'h300, 3'd7, 32'hFFFF_FFFF, 32'd1, 16'd8, 1'b0, 32'd0);
    tick(); clear_ex(); at_neg();
    check("bgtu_taken", {31'b0, resolved_taken}, 32'd1);
    br(32'h300, 3'd2, 32'hFFFF_FFFF, 32'd1, 16'd8, 1'b0, 32'd0);
    tick(); clear_ex(); at_neg();
    check("bgt_not_taken", {31'b0, resolved_taken}, 32'd0);

    // Reset mid-stream drops a pending redirect and ignores ex_valid
    br(32'h400, 3'd0, 32'd1, 32'd1, 16'd2, 1'b0, 32'd0);
    tick(); at_neg();
    check("pre_rst_mispredict", {31'b0, mispredict}, 32'd1);
    rst = 1;
    tick(); rst = 0; clear_ex(); at_neg();
    check("rst_drops_mispredict", {31'b0, mispredict}, 32'd0);
    check("rst_clears_redirect", redirect_pc, 32'd0);

`ifdef BRANCH_PREDICT_RAS_EN
    // Pre-allocate a RET entry, then push 5 returns into a 4-deep stack
    jr(32'h2A0, 32'd0, 1'b0, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      jmp(32'h200 + 32'(4 * k), 26'(k + 1), 1'b1, 1'b0, 32'd0);
      tick();
    end
    f_valid = 1; f_pc = 32'h2A0;
    for (int k = 0; k < 4; k++) begin
      jr(32'h2A0, 32'h214 - 32'(4 * k), 1'b1, 32'h214 - 32'(4 * k));
      at_neg();
      check("ras_top_taken", {31'b0, pred_taken}, 32'd1);
      check("ras_top_target", pred_target, 32'h214 - 32'(4 * k));
      tick();
    end
    clear_ex(); at_neg();
    check("ras_empty_not_taken", {31'b0, pred_taken}, 32'd0);
`endif

    // Randomized traffic over a small PC pool with index aliasing
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      f_valid = ($urandom_range(0, 3) != 0);
      f_pc    = pc_of($urandom_range(0, 11));
      s       = $urandom_range(0, 12);
      pt      = $urandom_range(0, 1);
      ptg     = $urandom_range(0, 1) ? $urandom : pc_of(s) + 32'(4 * $urandom_range(1, 3));
      if (s == 12) begin
        clear_ex(); ex_valid = 1; ex_pc = pc_of(3); ex_pred_taken = pt;
      end else if (s % 4 < 2) begin
        br(pc_of(s), 3'($urandom_range(0, 7)), pick_val(), pick_val(),
           16'($urandom_range(0, 65535)), pt, ptg);
      end else if (s % 4 == 2) begin
        jmp(pc_of(s), 26'($urandom), (s == 2 || s == 10), pt, ptg);
      end else begin
        jr(pc_of(s), ($urandom_range(0, 1) != 0) ? pc_of(s) + 32'h40 : $urandom, pt, ptg);
      end
      if ($urandom_range(0, 3) == 0) ex_valid = 0;
      tick();
    end
    rst = 0; clear_ex(); at_neg();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
